pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 6, number of pipeline stages (index 0 = PC, STAGES-1 = WB).
REQ-002 Parameter NOABORT, default 3, lowest stage index whose stall request blocks a flush (multi-cycle unit not abortable).
REQ-003 Parameter WDOG_W, default 16, watchdog counter width.
REQ-004 Parameter PC_W, default 32, redirect address width.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stallreq  in  STAGES  per-stage stall request; bit i = stage i cannot advance this cycle.
REQ-008 flush_req  in  1  one-cycle redirect request (exception/eret).
REQ-009 flush_pc  in  PC_W  redirect target, sampled with flush_req.
REQ-010 stall  out  STAGES  per-stage hold; bit i = stage i keeps its register.
REQ-011 bubble  out  STAGES  per-stage NOP insert into stage i's output register.
REQ-012 flush  out  STAGES  per-stage invalidate of pipeline register.
REQ-013 redirect_valid  out  1  one-cycle PC redirect strobe.
REQ-014 redirect_pc  out  PC_W  redirect target, valid with redirect_valid.
REQ-015 flush_pending  out  1  flush accepted but deferred.
REQ-016 wdog_timeout  out  1  sticky stall-watchdog expiry.
REQ-017 stall_cycles  out  32  saturating count of cycles with any stall bit set.

Function
REQ-018 k = highest index with stallreq[k]=1; stall[j]=1 for all j<=k, else 0; combinational from stallreq and state.
REQ-019 bubble[k+1]=1 when k<STAGES-1 and stall active; all other bubble bits 0.
REQ-020 No stall request -> stall=0, bubble=0.
REQ-021 Flush executes in cycle F: flush[j]=1 for j<STAGES-1 (WB never flushed), stall=0, bubble=0, redirect_valid=1, redirect_pc=latched target.
REQ-022 flush_req with no stallreq bit at index>=NOABORT -> flush executes same cycle (zero latency), target = flush_pc.
REQ-023 flush_req with any stallreq bit at index>=NOABORT -> flush_pc latched, flush_pending=1 next cycle; normal stall behaviour continues.
REQ-024 While flush_pending=1: flush executes in the first cycle all stallreq bits>=NOABORT are 0; flush_pending clears next edge.
REQ-025 New flush_req while flush_pending=1 -> latched target overwritten (last request wins); still one flush executed.
REQ-026 flush_req in the cycle a pending flush executes -> new flush_pc used, single flush.
REQ-027 redirect_valid is exactly one cycle per executed flush; never asserted otherwise.
REQ-028 Watchdog counter: increments each cycle any stall bit=1, clears on cycle with stall=0 or executed flush.
REQ-029 Counter reaching 2^WDOG_W-1 -> wdog_timeout=1 next edge, held until reset; counter saturates.
REQ-030 stall_cycles increments on every cycle with any stall bit=1; saturates at 0xFFFFFFFF, no wrap.
REQ-031 Pending-flush cycles with stall active count toward both counters.

Reset
REQ-032 rst=0 asynchronously: flush_pending=0, latched target=0, watchdog=0, wdog_timeout=0, stall_cycles=0.
REQ-033 During reset: stall=0, bubble=0, flush=0, redirect_valid=0, redirect_pc=0.
REQ-034 Reset asserted mid-pending-flush discards the flush; no redirect after release.
REQ-035 Reset deassertion needs no synchronous settling cycle; first post-reset edge acts normally.

Verification
REQ-036 STAGES=6, stallreq=6'b000100 -> stall=6'b000111, bubble=6'b001000, stall_cycles +1 per cycle.
REQ-037 stallreq=0, flush_req=1, flush_pc=0xBFC00380 -> same cycle flush=6'b011111, redirect_valid=1, redirect_pc=0xBFC00380.
REQ-038 stallreq[3]=1 held 5 cycles, flush_req pulse cycle 1 with 0x80000180 -> flush_pending=1 cycles 2..5; stallreq drops cycle 6 -> flush cycle 6 with 0x80000180, flush_pending=0 cycle 7.
REQ-039 As REQ-038 plus second flush_req cycle 3 with 0x80000200 -> single redirect, target 0x80000200.
REQ-040 WDOG_W=4, stallreq[2]=1 held 20 cycles -> wdog_timeout=1 from cycle 16, stays 1 after stallreq drops.
REQ-041 rst=0 asserted while flush_pending=1 -> all outputs 0 immediately; after release, no redirect_valid with stallreq=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and flush requests in,
// per-stage hold/bubble/flush controls and the PC redirect out.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int PC_W   = 32
);
    logic [STAGES-1:0] stallreq;
    logic              flush_req;
    logic [PC_W-1:0]   flush_pc;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] flush;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        output stallreq, flush_req, flush_pc,
        input  stall, bubble, flush,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  stallreq, flush_req, flush_pc,
        output stall, bubble, flush,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall propagation, bubble insertion,
// deferrable flush with PC redirect, stall watchdog and stall counter.
module pipe_ctrl #(
    parameter int STAGES  = 6,
    parameter int NOABORT = 3,
    parameter int WDOG_W  = 16,
    parameter int PC_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus,
    output logic        flush_pending,
    output logic        wdog_timeout,
    output logic [31:0] stall_cycles
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [STAGES-1:0] FLUSH_MASK = {1'b0, {(STAGES-1){1'b1}}};
    localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   pc_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bub;
    logic [STAGES-1:0] stall_c;
    logic              acc;
    logic              late_busy;
    logic              exec;
    logic              any_stall;

    // hold[i] = some stage at or above i requests a stall
    always_comb begin
        acc  = 1'b0;
        hold = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc     = acc | bus.stallreq[i];
            hold[i] = acc;
        end
    end

    always_comb begin
        bub = '0;
        for (int i = 1; i < STAGES; i++) begin
            bub[i] = hold[i-1] & ~hold[i];
        end
    end

    assign late_busy = hold[NOABORT];
    assign exec      = rst
                     & (bus.flush_req | (state_q == PEND))
                     & ~late_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.flush_req && late_busy) state_d = PEND;
            PEND: if (!late_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_c            = '0;
        bus.bubble         = '0;
        bus.flush          = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        flush_pending      = (state_q == PEND);
        if (exec) begin
            bus.flush          = FLUSH_MASK;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = bus.flush_req ? bus.flush_pc : pc_q;
        end else if (rst) begin
            stall_c    = hold;
            bus.bubble = bub;
        end
    end

    assign bus.stall = stall_c;
    assign any_stall = |stall_c;

    // Deferred target; a newer request always replaces it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else if (bus.flush_req && !exec) begin
            pc_q <= bus.flush_pc;
        end
    end

    always_comb begin
        wdog_d = '0;
        if (any_stall) begin
            wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q       <= '0;
            wdog_timeout <= 1'b0;
            stall_cycles <= '0;
        end else begin
            wdog_q <= wdog_d;
            if (wdog_d == WDOG_MAX) begin
                wdog_timeout <= 1'b1;
            end
            if (any_stall && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stalls, immediate and deferred flushes,
// watchdog expiry and reset behaviour, with hand-computed expectations.
module tb_pipe_ctrl;
    logic        clk;
    logic        rst;
    logic        flush_pending;
    logic        wdog_timeout;
    logic [31:0] stall_cycles;
    int          n_vec;
    int          n_err;
    int          sc_exp;

    pipe_ctrl_if #(.STAGES(6), .PC_W(32)) bus ();

    pipe_ctrl #(
        .STAGES(6), .NOABORT(3), .WDOG_W(4), .PC_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush_pending(flush_pending),
        .wdog_timeout (wdog_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stallreq  = 6'b001000;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_1234;
        #2;
        n_vec++; if (bus.stall !== 6'b0) begin
            n_err++; $display("FAIL rst_stall: got %b want 000000", bus.stall); end
        n_vec++; if (bus.bubble !== 6'b0) begin
            n_err++; $display("FAIL rst_bubble: got %b want 000000", bus.bubble); end
        n_vec++; if (bus.flush !== 6'b0) begin
            n_err++; $display("FAIL rst_flush: got %b want 000000", bus.flush); end
        n_vec++; if (bus.redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_rv: got %b want 0", bus.redirect_valid); end
        n_vec++; if (bus.redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL rst_rpc: got %h want 0", bus.redirect_pc); end
        n_vec++; if (flush_pending !== 1'b0) begin
            n_err++; $display("FAIL rst_pend: got %b want 0", flush_pending); end
        n_vec++; if (wdog_timeout !== 1'b0) begin
            n_err++; $display("FAIL rst_wdog: got %b want 0", wdog_timeout); end
        n_vec++; if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL rst_sc: got %0d want 0", stall_cycles); end
        tick();
        tick();
        n_vec++; if (flush_pending !== 1'b0) begin
            n_err++; $display("FAIL rst_pend_held: got %b want 0", flush_pending); end
        bus.stallreq  = 6'b0;
        bus.flush_req = 1'b0;
        bus.flush_pc  = 32'h0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        bus.stallreq = 6'b000100;
        #1;
        n_vec++; if (bus.stall !== 6'b000111) begin
            n_err++; $display("FAIL stall_k2: got %b want 000111", bus.stall); end
        n_vec++; if (bus.bubble !== 6'b001000) begin
            n_err++; $display("FAIL bubble_k2: got %b want 001000", bus.bubble); end
        tick();
        n_vec++; if (stall_cycles !== 32'd1) begin
            n_err++; $display("FAIL sc_1: got %0d want 1", stall_cycles); end
        tick();
        n_vec++; if (stall_cycles !== 32'd2) begin
            n_err++; $display("FAIL sc_2: got %0d want 2", stall_cycles); end
        bus.stallreq = 6'b100000;
        #1;
        n_vec++; if (bus.stall !== 6'b111111) begin
            n_err++; $display("FAIL stall_k5: got %b want 111111", bus.stall); end
        n_vec++; if (bus.bubble !== 6'b000000) begin
            n_err++; $display("FAIL bubble_k5: got %b want 000000", bus.bubble); end
        tick();
        bus.stallreq = 6'b010010;
        #1;
        n_vec++; if (bus.stall !== 6'b011111) begin
            n_err++; $display("FAIL stall_k4: got %b want 011111", bus.stall); end
        n_vec++; if (bus.bubble !== 6'b100000) begin
            n_err++; $display("FAIL bubble_k4: got %b want 100000", bus.bubble); end
        tick();
        bus.stallreq = 6'b000001;
        #1;
        n_vec++; if (bus.stall !== 6'b000001) begin
            n_err++; $display("FAIL stall_k0: got %b want 000001", bus.stall); end
        n_vec++; if (bus.bubble !== 6'b000010) begin
            n_err++; $display("FAIL bubble_k0: got %b want 000010", bus.bubble); end
        tick();
        bus.stallreq = 6'b0;
        #1;
        n_vec++; if (bus.stall !== 6'b0 || bus.bubble !== 6'b0) begin
            n_err++; $display("FAIL idle: got stall %b bubble %b want 0 0",
                              bus.stall, bus.bubble); end
        tick();
        sc_exp = 5;
        n_vec++; if (stall_cycles !== sc_exp) begin
            n_err++; $display("FAIL sc_5: got %0d want %0d", stall_cycles, sc_exp); end
    endtask

    task automatic test_flush_now();
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'hBFC0_0380;
        #1;
        n_vec++; if (bus.flush !== 6'b011111) begin
            n_err++; $display("FAIL now_flush: got %b want 011111", bus.flush); end
        n_vec++; if (bus.redirect_valid !== 1'b1) begin
            n_err++; $display("FAIL now_rv: got %b want 1", bus.redirect_valid); end
        n_vec++; if (bus.redirect_pc !== 32'hBFC0_0380) begin
            n_err++; $display("FAIL now_rpc: got %h want bfc00380", bus.redirect_pc); end
        tick();
        bus.flush_req = 1'b0;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b0 || flush_pending !== 1'b0) begin
            n_err++; $display("FAIL now_after: got rv %b pend %b want 0 0",
                              bus.redirect_valid, flush_pending); end
        n_vec++; if (bus.redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL now_rpc_idle: got %h want 0", bus.redirect_pc); end
        bus.stallreq  = 6'b000100;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_0040;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b1 || bus.flush !== 6'b011111) begin
            n_err++; $display("FAIL low_flush: got rv %b flush %b want 1 011111",
                              bus.redirect_valid, bus.flush); end
        n_vec++; if (bus.stall !== 6'b0 || bus.bubble !== 6'b0) begin
            n_err++; $display("FAIL low_stall: got stall %b bubble %b want 0 0",
                              bus.stall, bus.bubble); end
        tick();
        bus.stallreq  = 6'b0;
        bus.flush_req = 1'b0;
        #1;
        n_vec++; if (stall_cycles !== sc_exp || flush_pending !== 1'b0) begin
            n_err++; $display("FAIL low_after: got sc %0d pend %b want %0d 0",
                              stall_cycles, flush_pending, sc_exp); end
    endtask

    task automatic test_flush_deferred(input logic second);
        int          rv_cnt;
        logic [31:0] tgt;
        rv_cnt = 0;
        tgt = second ? 32'h8000_0200 : 32'h8000_0180;
        bus.stallreq  = 6'b001000;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h8000_0180;
        #1;
        if (bus.redirect_valid === 1'b1) rv_cnt++;
        n_vec++; if (bus.stall !== 6'b001111 || bus.bubble !== 6'b010000) begin
            n_err++; $display("FAIL def_c1: got stall %b bubble %b want 001111 010000",
                              bus.stall, bus.bubble); end
        tick();
        for (int c = 2; c <= 5; c++) begin
            bus.flush_req = second && (c == 3);
            bus.flush_pc  = (second && c == 3) ? 32'h8000_0200 : 32'h0;
            #1;
            if (bus.redirect_valid === 1'b1) rv_cnt++;
            n_vec++; if (flush_pending !== 1'b1 || bus.flush !== 6'b0) begin
                n_err++; $display("FAIL def_pend_c%0d: got pend %b flush %b want 1 000000",
                                  c, flush_pending, bus.flush); end
            tick();
        end
        bus.flush_req = 1'b0;
        bus.stallreq  = 6'b0;
        #1;
        if (bus.redirect_valid === 1'b1) rv_cnt++;
        n_vec++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== tgt) begin
            n_err++; $display("FAIL def_exec: got rv %b pc %h want 1 %h",
                              bus.redirect_valid, bus.redirect_pc, tgt); end
        n_vec++; if (bus.flush !== 6'b011111 || flush_pending !== 1'b1) begin
            n_err++; $display("FAIL def_exec_flush: got %b pend %b want 011111 1",
                              bus.flush, flush_pending); end
        tick();
        if (bus.redirect_valid === 1'b1) rv_cnt++;
        n_vec++; if (flush_pending !== 1'b0) begin
            n_err++; $display("FAIL def_c7: got pend %b want 0", flush_pending); end
        n_vec++; if (rv_cnt != 1) begin
            n_err++; $display("FAIL def_rv_count: got %0d want 1", rv_cnt); end
        sc_exp += 5;
        n_vec++; if (stall_cycles !== sc_exp) begin
            n_err++; $display("FAIL def_sc: got %0d want %0d", stall_cycles, sc_exp); end
    endtask

    task automatic test_flush_collide();
        bus.stallreq  = 6'b010000;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'hA000_0000;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b0 || bus.stall !== 6'b011111) begin
            n_err++; $display("FAIL col_c1: got rv %b stall %b want 0 011111",
                              bus.redirect_valid, bus.stall); end
        tick();
        sc_exp += 1;
        bus.stallreq = 6'b0;
        bus.flush_pc = 32'hA000_0100;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hA000_0100) begin
            n_err++; $display("FAIL col_exec: got rv %b pc %h want 1 a0000100",
                              bus.redirect_valid, bus.redirect_pc); end
        tick();
        bus.flush_req = 1'b0;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b0 || flush_pending !== 1'b0) begin
            n_err++; $display("FAIL col_after: got rv %b pend %b want 0 0",
                              bus.redirect_valid, flush_pending); end
    endtask

    task automatic test_watchdog();
        bus.stallreq = 6'b000100;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (i == 15) begin
                n_vec++; if (wdog_timeout !== 1'b0) begin
                    n_err++; $display("FAIL wdog_c15: got %b want 0", wdog_timeout); end
            end
            if (i == 16) begin
                n_vec++; if (wdog_timeout !== 1'b1) begin
                    n_err++; $display("FAIL wdog_c16: got %b want 1", wdog_timeout); end
            end
            tick();
        end
        sc_exp += 20;
        bus.stallreq = 6'b0;
        tick();
        tick();
        n_vec++; if (wdog_timeout !== 1'b1) begin
            n_err++; $display("FAIL wdog_sticky: got %b want 1", wdog_timeout); end
        n_vec++; if (stall_cycles !== sc_exp) begin
            n_err++; $display("FAIL wdog_sc: got %0d want %0d", stall_cycles, sc_exp); end
    endtask

    task automatic test_reset_pending();
        bus.stallreq  = 6'b001000;
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'hDEAD_0000;
        tick();
        bus.flush_req = 1'b0;
        #1;
        n_vec++; if (flush_pending !== 1'b1) begin
            n_err++; $display("FAIL rp_pend: got %b want 1", flush_pending); end
        rst = 1'b0;
        #1;
        n_vec++; if (flush_pending !== 1'b0 || bus.stall !== 6'b0) begin
            n_err++; $display("FAIL rp_async: got pend %b stall %b want 0 000000",
                              flush_pending, bus.stall); end
        n_vec++; if (stall_cycles !== 32'd0 || wdog_timeout !== 1'b0) begin
            n_err++; $display("FAIL rp_cnt: got sc %0d wdog %b want 0 0",
                              stall_cycles, wdog_timeout); end
        tick();
        bus.stallreq = 6'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 6'b0) begin
            n_err++; $display("FAIL rp_rel: got rv %b flush %b want 0 000000",
                              bus.redirect_valid, bus.flush); end
        tick();
        n_vec++; if (bus.redirect_valid !== 1'b0 || flush_pending !== 1'b0) begin
            n_err++; $display("FAIL rp_post: got rv %b pend %b want 0 0",
                              bus.redirect_valid, flush_pending); end
        bus.stallreq = 6'b000100;
        tick();
        bus.stallreq = 6'b0;
        n_vec++; if (stall_cycles !== 32'd1) begin
            n_err++; $display("FAIL rp_first_edge: got %0d want 1", stall_cycles); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sc_exp = 0;
        test_reset();
        test_stall();
        test_flush_now();
        test_flush_deferred(1'b0);
        test_flush_deferred(1'b1);
        test_flush_collide();
        test_watchdog();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
